// File: rtl/s2_conv_scheduler_pkg.sv
// Shared types and constants for the stage-2 convolution scheduler.
// Latency: none (package only).
// Backpressure: not applicable.
package s2_pkg;

   localparam int S2_ROWS    = 8;
   localparam int S2_CHANS   = 3;
   localparam int S2_KSIZE   = 3;
   localparam int S2_NFILT   = 4;
   localparam int S2_OUT_DIM = S2_ROWS - S2_KSIZE + 1;        // 6
   localparam int S2_NWORDS  = S2_ROWS * S2_ROWS * S2_CHANS;  // 192
   localparam int S2_NOUT    = S2_OUT_DIM * S2_OUT_DIM * S2_NFILT; // 144

   // Explicit encodings keep the state values stable for anything that
   // decodes them outside this block.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      DRAIN = 3'd2,
      PROC  = 3'd3,
      DONE  = 3'd4
   } s2_state_t;

   // One tensor-builder load word: strobe plus its coordinates.
   typedef struct packed {
      logic       load_en;
      logic [2:0] row;
      logic [2:0] col;
      logic [1:0] cha;
   } s2_coord_t;

endpackage

// File: rtl/s2_conv_scheduler_coord_delay.sv
// Delays the LOAD-cycle coordinate word so it lines up with BRAM read data.
// Latency: READ_LAT cycles, fixed.
// Backpressure: none; free-running shift register.
// Ports: i_clk/i_reset clock and async reset, i_coord word in, o_coord word out.
module s2_coord_delay
   import s2_pkg::*;
#(
   parameter int READ_LAT = 1
) (
   input  logic      i_clk,
   input  logic      i_reset,
   input  s2_coord_t i_coord,
   output s2_coord_t o_coord
);

   s2_coord_t r_pipe [READ_LAT];

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < READ_LAT; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_coord;
         for (int i = 1; i < READ_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_coord = r_pipe[READ_LAT-1];

endmodule

// File: rtl/s2_conv_scheduler.sv
// Stage-2 sequencer: streams the 8x8x3 stage-1 tensor from BRAM, then walks 4 filters x 6x6 positions.
// Latency: 192+READ_LAT cycles from start to first proc_valid; one position per accepted handshake.
// Backpressure: proc_* outputs hold while i_proc_ready is low; the load phase is never stalled.
// Ports: i_clk, i_reset (async, active high), i_data_done (rising edge starts a run),
//   o_enable_read/o_read_addr to BRAM, o_load_en/o_row_addr/o_col_addr/o_cha_addr to the
//   tensor builder, o_filter_used/o_proc_dir/o_proc_counter/o_out_addr/o_proc_valid with
//   i_proc_ready to the datapath, o_busy and o_done status.
module s2_conv_scheduler
   import s2_pkg::*;
#(
   parameter int READ_LAT = 1   // 1..3
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_data_done,
   output logic       o_enable_read,
   output logic [7:0] o_read_addr,
   output logic       o_load_en,
   output logic [2:0] o_row_addr,
   output logic [2:0] o_col_addr,
   output logic [1:0] o_cha_addr,
   output logic [1:0] o_filter_used,
   output logic [1:0] o_proc_dir,
   output logic [5:0] o_proc_counter,
   output logic [7:0] o_out_addr,
   output logic       o_proc_valid,
   input  logic       i_proc_ready,
   output logic       o_busy,
   output logic       o_done
);

   s2_state_t  r_state;
   logic       r_data_done_q;
   logic [7:0] r_read_addr;
   logic [1:0] r_drain_cnt;
   logic [2:0] r_out_row;
   logic [2:0] r_out_col;
   logic [1:0] r_proc_dir;
   logic [5:0] r_proc_counter;
   logic [7:0] r_out_addr;

   logic       w_start;
   logic       w_accept;
   logic       w_last_pos;
   s2_coord_t  w_coord_in;
   s2_coord_t  w_coord_out;

   // Level-high data_done must not retrigger; only a fresh rising edge starts a run.
   assign w_start    = i_data_done & ~r_data_done_q;
   assign w_accept   = (r_state == PROC) & i_proc_ready;
   assign w_last_pos = (r_proc_dir == 2'(S2_NFILT - 1)) &&
                       (r_out_row  == 3'(S2_OUT_DIM - 1)) &&
                       (r_out_col  == 3'(S2_OUT_DIM - 1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state        <= IDLE;
         r_data_done_q  <= 1'b0;
         r_read_addr    <= '0;
         r_drain_cnt    <= '0;
         r_out_row      <= '0;
         r_out_col      <= '0;
         r_proc_dir     <= '0;
         r_proc_counter <= '0;
         r_out_addr     <= '0;
      end else begin
         r_data_done_q <= i_data_done;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state        <= LOAD;
                  r_read_addr    <= '0;
                  r_out_row      <= '0;
                  r_out_col      <= '0;
                  r_proc_dir     <= '0;
                  r_proc_counter <= '0;
                  r_out_addr     <= '0;
               end
            end
            LOAD: begin
               if (r_read_addr == 8'(S2_NWORDS - 1)) begin
                  r_state     <= DRAIN;
                  r_drain_cnt <= '0;
               end else begin
                  r_read_addr <= r_read_addr + 8'd1;
               end
            end
            // Hold off processing until the last BRAM word has been loaded.
            DRAIN: begin
               if (r_drain_cnt == 2'(READ_LAT - 1)) r_state <= PROC;
               else                                  r_drain_cnt <= r_drain_cnt + 2'd1;
            end
            PROC: begin
               if (w_accept) begin
                  // The final position leaves the counters parked at 3/35/143.
                  if (w_last_pos) begin
                     r_state <= DONE;
                  end else begin
                     r_out_addr <= r_out_addr + 8'd1;
                     if (r_out_col == 3'(S2_OUT_DIM - 1)) begin
                        r_out_col <= '0;
                        if (r_out_row == 3'(S2_OUT_DIM - 1)) begin
                           r_out_row      <= '0;
                           r_proc_dir     <= r_proc_dir + 2'd1;
                           r_proc_counter <= '0;
                        end else begin
                           r_out_row      <= r_out_row + 3'd1;
                           r_proc_counter <= r_proc_counter + 6'd1;
                        end
                     end else begin
                        r_out_col      <= r_out_col + 3'd1;
                        r_proc_counter <= r_proc_counter + 6'd1;
                     end
                  end
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Coordinates are zeroed outside LOAD so idle tensor-builder inputs stay quiet.
   always_comb begin
      w_coord_in = '0;
      if (r_state == LOAD) begin
         w_coord_in.load_en = 1'b1;
         w_coord_in.cha     = r_read_addr[7:6];
         w_coord_in.row     = r_read_addr[5:3];
         w_coord_in.col     = r_read_addr[2:0];
      end
   end

   s2_coord_delay #(.READ_LAT(READ_LAT)) u_coord_delay (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_coord (w_coord_in),
      .o_coord (w_coord_out)
   );

   assign o_enable_read  = (r_state == LOAD);
   assign o_read_addr    = r_read_addr;
   assign o_load_en      = w_coord_out.load_en;
   assign o_row_addr     = w_coord_out.row;
   assign o_col_addr     = w_coord_out.col;
   assign o_cha_addr     = w_coord_out.cha;
   assign o_proc_dir     = r_proc_dir;
   assign o_filter_used  = r_proc_dir;
   assign o_proc_counter = r_proc_counter;
   assign o_out_addr     = r_out_addr;
   assign o_proc_valid   = (r_state == PROC);
   assign o_busy         = (r_state != IDLE);
   assign o_done         = (r_state == DONE);

endmodule

// File: tb/tb_s2_conv_scheduler.sv
// Bench for s2_conv_scheduler: two instances (READ_LAT 1 and 3) driven with shared inputs,
// each compared every cycle against a counter/arithmetic reference model, plus a
// directed vector table and corner-case sequences.
module tb_s2_conv_scheduler;

   typedef struct packed {
      logic       en;
      logic [7:0] ra;
      logic       le;
      logic [2:0] row;
      logic [2:0] col;
      logic [1:0] cha;
      logic [1:0] fu;
      logic [1:0] dir;
      logic [5:0] ctr;
      logic [7:0] oa;
      logic       vld;
      logic       busy;
      logic       done;
   } obs_t;

   typedef struct {
      logic       rst, dd, rdy;
      logic       busy, en;
      logic [7:0] ra;
      logic       le;
      logic [2:0] row, col;
      logic [1:0] cha;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, dd, rdy;

   logic       w1_en, w1_le, w1_vld, w1_busy, w1_done;
   logic [7:0] w1_ra, w1_oa;
   logic [2:0] w1_row, w1_col;
   logic [1:0] w1_cha, w1_fu, w1_dir;
   logic [5:0] w1_ctr;
   logic       w3_en, w3_le, w3_vld, w3_busy, w3_done;
   logic [7:0] w3_ra, w3_oa;
   logic [2:0] w3_row, w3_col;
   logic [1:0] w3_cha, w3_fu, w3_dir;
   logic [5:0] w3_ctr;

   s2_conv_scheduler #(.READ_LAT(1)) dut1 (
      .i_clk(clk), .i_reset(rst), .i_data_done(dd),
      .o_enable_read(w1_en), .o_read_addr(w1_ra), .o_load_en(w1_le),
      .o_row_addr(w1_row), .o_col_addr(w1_col), .o_cha_addr(w1_cha),
      .o_filter_used(w1_fu), .o_proc_dir(w1_dir), .o_proc_counter(w1_ctr),
      .o_out_addr(w1_oa), .o_proc_valid(w1_vld), .i_proc_ready(rdy),
      .o_busy(w1_busy), .o_done(w1_done));

   s2_conv_scheduler #(.READ_LAT(3)) dut3 (
      .i_clk(clk), .i_reset(rst), .i_data_done(dd),
      .o_enable_read(w3_en), .o_read_addr(w3_ra), .o_load_en(w3_le),
      .o_row_addr(w3_row), .o_col_addr(w3_col), .o_cha_addr(w3_cha),
      .o_filter_used(w3_fu), .o_proc_dir(w3_dir), .o_proc_counter(w3_ctr),
      .o_out_addr(w3_oa), .o_proc_valid(w3_vld), .i_proc_ready(rdy),
      .o_busy(w3_busy), .o_done(w3_done));

   obs_t obs1, obs3;
   assign obs1 = {w1_en, w1_ra, w1_le, w1_row, w1_col, w1_cha, w1_fu, w1_dir,
                  w1_ctr, w1_oa, w1_vld, w1_busy, w1_done};
   assign obs3 = {w3_en, w3_ra, w3_le, w3_row, w3_col, w3_cha, w3_fu, w3_dir,
                  w3_ctr, w3_oa, w3_vld, w3_busy, w3_done};

   int n_chk = 0, n_pass = 0;
   int n_cyc = 0;

   // Reference model: per instance a run flag, cycles since start and accepted positions.
   bit         m_act [2];
   int         m_t   [2];
   int         m_k   [2];
   logic [7:0] m_ra_idle [2];
   bit         m_prev;
   int         acc_idx;

   // Statistics for the READ_LAT=1 instance and timing marks for READ_LAT=3.
   int busy_cnt1, done_cnt1, done_cnt3;
   int last_oa1;
   int ra191_n3, lastle_n3, firstproc_n3;

   function automatic int lat(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic obs_t exp_obs(input int i);
      obs_t o;
      int L, t, k, w, idx;
      o = '0;
      L = lat(i);
      t = m_t[i];
      k = m_k[i];
      if (m_act[i]) begin
         o.busy = 1'b1;
         if (t < 192) begin
            o.en = 1'b1;
            o.ra = 8'(t);
         end else begin
            o.ra = 8'd191;
         end
         w = t - L;
         if (w >= 0 && w < 192) begin
            o.le  = 1'b1;
            o.cha = 2'(w / 64);
            o.row = 3'((w / 8) % 8);
            o.col = 3'(w % 8);
         end
         if (t >= 192 + L && k < 144) o.vld = 1'b1;
         if (k == 144) o.done = 1'b1;
      end else begin
         o.ra = m_ra_idle[i];
      end
      idx   = (k > 143) ? 143 : k;
      o.dir = 2'(idx / 36);
      o.fu  = o.dir;
      o.ctr = 6'(idx % 36);
      o.oa  = 8'(idx);
      return o;
   endfunction

   task automatic model_step(input logic d, input logic r, input logic rs);
      bit st;
      st = d && !m_prev;
      if (rs) begin
         m_prev  = 1'b0;
         acc_idx = 0;
         for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0; m_t[i] = 0; m_k[i] = 0; m_ra_idle[i] = 8'd0;
         end
      end else begin
         m_prev = d;
         for (int i = 0; i < 2; i++) begin
            if (!m_act[i]) begin
               if (st) begin
                  m_act[i] = 1'b1; m_t[i] = 0; m_k[i] = 0;
                  if (i == 0) acc_idx = 0;
               end
            end else if (m_k[i] == 144) begin
               m_act[i] = 1'b0;
               m_ra_idle[i] = 8'd191;
            end else begin
               if (m_t[i] >= 192 + lat(i) && r) m_k[i]++;
               m_t[i]++;
            end
         end
      end
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, n_cyc);
   endtask

   // One clock: apply inputs after a falling edge, step the model, observe at the next falling edge.
   task automatic cyc(input logic d, input logic r, input logic rs);
      if (w1_vld === 1'b1 && r && !rs) begin
         check("accept_order", int'(w1_dir) * 36 + int'(w1_ctr), acc_idx);
         acc_idx++;
      end
      dd = d; rdy = r; rst = rs;
      model_step(d, r, rs);
      @(posedge clk);
      @(negedge clk);
      n_cyc++;
      check("model_rl1", obs1, exp_obs(0));
      check("model_rl3", obs3, exp_obs(1));
      if (w1_busy) busy_cnt1++;
      if (w1_done) begin done_cnt1++; last_oa1 = int'(w1_oa); end
      if (w3_done) done_cnt3++;
      if (w3_en && w3_ra == 8'd191) ra191_n3 = n_cyc;
      if (w3_le && w3_cha == 2'd2 && w3_row == 3'd7 && w3_col == 3'd7) lastle_n3 = n_cyc;
      if (w3_vld && firstproc_n3 < 0) firstproc_n3 = n_cyc;
   endtask

   task automatic clear_stats();
      busy_cnt1 = 0; done_cnt1 = 0; done_cnt3 = 0; last_oa1 = -1;
   endtask

   vec_t tbl [8];
   int   b;

   initial begin
      rst = 1'b0; dd = 1'b0; rdy = 1'b0;
      m_prev = 1'b0; acc_idx = 0;
      ra191_n3 = -1; lastle_n3 = -1; firstproc_n3 = -1;
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 1'b0; m_t[i] = 0; m_k[i] = 0; m_ra_idle[i] = 8'd0;
      end
      clear_stats();
      #2;

      // rst dd rdy | busy en ra le row col cha  (READ_LAT=1 instance)
      tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 3'd0, 2'd0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 3'd0, 2'd0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 3'd0, 3'd0, 2'd0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 3'd0, 3'd0, 2'd0};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 3'd0, 3'd1, 2'd0};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 3'd0, 3'd2, 2'd0};
      tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd4, 1'b1, 3'd0, 3'd3, 2'd0};
      tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5, 1'b1, 3'd0, 3'd4, 2'd0};
      for (int i = 0; i < 8; i++) begin
         cyc(tbl[i].dd, tbl[i].rdy, tbl[i].rst);
         check($sformatf("table_%0d", i),
               {w1_busy, w1_en, w1_ra, w1_le, w1_row, w1_col, w1_cha},
               {tbl[i].busy, tbl[i].en, tbl[i].ra, tbl[i].le, tbl[i].row, tbl[i].col, tbl[i].cha});
      end

      // First run: word 65 coordinates, then proc_ready tied high to completion.
      b = 0;
      while (w1_ra != 8'd66 && b < 300) begin cyc(1'b0, 1'b0, 1'b0); b++; end
      check("reach_addr66", w1_ra, 66);
      check("word65_coords", {w1_le, w1_row, w1_col, w1_cha}, {1'b1, 3'd0, 3'd1, 2'd1});
      b = 0;
      while ((w1_busy || w3_busy) && b < 2000) begin cyc(1'b0, 1'b1, 1'b0); b++; end
      check("run1_finished", {w1_busy, w3_busy}, 0);
      check("run1_busy_cycles", busy_cnt1, 192 + 1 + 144 + 1);
      check("run1_done_pulses", done_cnt1, 1);
      check("run1_last_out_addr", last_oa1, 143);
      check("run1_accept_count", acc_idx, 144);
      check("rl3_last_load_gap", lastle_n3 - ra191_n3, 3);
      check("rl3_proc_after_load", firstproc_n3, lastle_n3 + 1);

      // Second run: ready pattern 1,0,0 repeating, data_done held high throughout.
      clear_stats();
      cyc(1'b1, 1'b0, 1'b0);
      b = 0;
      while ((w1_busy || w3_busy) && b < 3000) begin
         cyc(1'b1, (b % 3 == 0) ? 1'b1 : 1'b0, 1'b0);
         b++;
      end
      check("run2_finished", {w1_busy, w3_busy}, 0);
      check("run2_accept_count", acc_idx, 144);
      check("run2_done_pulses", {done_cnt1, done_cnt3}, {32'd1, 32'd1});
      clear_stats();
      for (int i = 0; i < 40; i++) cyc(1'b1, $urandom_range(0, 1) == 1, 1'b0);
      check("held_high_no_rerun", busy_cnt1, 0);

      // Third run: fresh edge, reset at read_addr 100.
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      check("rerun_start", {w1_busy, w1_en, w1_ra}, {1'b1, 1'b1, 8'd0});
      b = 0;
      while (w1_ra != 8'd100 && b < 400) begin cyc(1'b1, 1'b1, 1'b0); b++; end
      check("reach_addr100", w1_ra, 100);
      cyc(1'b0, 1'b1, 1'b1);
      check("reset_in_load", {obs1, obs3}, 0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      check("idle_after_reset", {w1_busy, w3_busy}, 0);

      // Fourth run: reset during PROC at proc_counter 20, random ready.
      cyc(1'b1, 1'b1, 1'b0);
      check("restart_addr0", {w1_busy, w1_ra}, {1'b1, 8'd0});
      b = 0;
      while (!(w1_vld && w1_ctr == 6'd20) && b < 800) begin
         cyc(1'b1, $urandom_range(0, 3) != 0, 1'b0);
         b++;
      end
      check("reach_ctr20", {w1_vld, w1_ctr}, {1'b1, 6'd20});
      cyc(1'b0, 1'b1, 1'b1);
      check("reset_in_proc", {obs1, obs3}, 0);
      cyc(1'b0, 1'b0, 1'b0);

      // Fifth run: random ready and random data_done glitches while busy.
      clear_stats();
      cyc(1'b1, 1'b0, 1'b0);
      b = 0;
      while ((w1_busy || w3_busy) && b < 4000) begin
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, 1'b0);
         b++;
      end
      check("run5_finished", {w1_busy, w3_busy}, 0);
      check("run5_done_pulses", {done_cnt1, done_cnt3}, {32'd1, 32'd1});
      check("run5_accept_count", acc_idx, 144);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
